// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - packet round-robin drain of three router FIFOs onto one back-pressured byte channel
module router_out_arbiter #(
  parameter int TIMEOUT_EN = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_0,
  input  logic       vld_1,
  input  logic       vld_2,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_port,
  output logic       m_last,
  output logic       pkt_abort,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [6:0] remaining_q, remaining_d;
  logic       inflight_q, inflight_d;
  logic [1:0] infl_port_q, infl_port_d;
  logic       infl_last_q, infl_last_d;
  logic [7:0] buf_data_q [2];
  logic [7:0] buf_data_d [2];
  logic [1:0] buf_port_q [2];
  logic [1:0] buf_port_d [2];
  logic       buf_last_q [2];
  logic       buf_last_d [2];
  logic [1:0] occ_q, occ_d;
  logic       pkt_abort_q, pkt_abort_d;

  logic [2:0] vld_vec, srst_vec;
  logic [1:0] c0, c1, c2, pick, rd_port, occ_pop;
  logic [2:0] need;
  logic [7:0] cap_data;
  logic       pop, permit, abort_now, capture, rd_en, rd_last;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign vld_vec  = {vld_2, vld_1, vld_0};
  assign srst_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_data_q[0];
  assign m_port    = buf_port_q[0];
  assign m_last    = buf_last_q[0] & m_valid;
  assign pkt_abort = pkt_abort_q;
  assign busy      = (state_q != IDLE);

  assign read_enb_0 = rd_en && (rd_port == 2'd0);
  assign read_enb_1 = rd_en && (rd_port == 2'd1);
  assign read_enb_2 = rd_en && (rd_port == 2'd2);

  // Rotating priority: search starts one past the last granted port.
  always_comb begin
    c0 = inc3(last_grant_q);
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (vld_vec[c0])      pick = c0;
    else if (vld_vec[c1]) pick = c1;
    else                  pick = c2;
  end

  always_comb begin
    case (infl_port_q)
      2'd1:    cap_data = data_1;
      2'd2:    cap_data = data_2;
      default: cap_data = data_0;
    endcase
    pop       = m_valid & m_ready;
    need      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    permit    = (need < 3'd2);
    abort_now = (TIMEOUT_EN != 0) && (state_q != IDLE) && srst_vec[grant_q];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    rd_en        = 1'b0;
    rd_port      = grant_q;
    rd_last      = 1'b0;
    pkt_abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|vld_vec) && permit) begin
          rd_en        = 1'b1;
          rd_port      = pick;
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = HDR;
        end
      end
      HDR: begin
        if (abort_now) begin
          state_d     = IDLE;
          pkt_abort_d = 1'b1;
        end else begin
          remaining_d = {1'b0, cap_data[7:2]} + 7'd1;
          state_d     = BODY;
        end
      end
      BODY: begin
        if (abort_now) begin
          state_d     = IDLE;
          pkt_abort_d = 1'b1;
        end else if (vld_vec[grant_q] && permit) begin
          rd_en       = 1'b1;
          rd_last     = (remaining_q == 7'd1);
          remaining_d = remaining_q - 7'd1;
          if (remaining_q == 7'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) rd_en = 1'b0;
    inflight_d  = rd_en;
    infl_port_d = rd_port;
    infl_last_d = rd_last;
  end

  // Output buffer: pop shifts the head, capture lands behind whatever remains.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_port_d = buf_port_q;
    buf_last_d = buf_last_q;
    capture    = inflight_q & ~abort_now;
    occ_pop    = occ_q - {1'b0, pop};
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_port_d[0] = buf_port_q[1];
      buf_last_d[0] = buf_last_q[1];
    end
    if (capture) begin
      if (occ_pop == 2'd0) begin
        buf_data_d[0] = cap_data;
        buf_port_d[0] = infl_port_q;
        buf_last_d[0] = infl_last_q;
      end else begin
        buf_data_d[1] = cap_data;
        buf_port_d[1] = infl_port_q;
        buf_last_d[1] = infl_last_q;
      end
    end
    occ_d = occ_pop + {1'b0, capture};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      remaining_q  <= 7'd0;
      inflight_q   <= 1'b0;
      infl_port_q  <= 2'd0;
      infl_last_q  <= 1'b0;
      buf_data_q   <= '{default: 8'd0};
      buf_port_q   <= '{default: 2'd0};
      buf_last_q   <= '{default: 1'b0};
      occ_q        <= 2'd0;
      pkt_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      inflight_q   <= inflight_d;
      infl_port_q  <= infl_port_d;
      infl_last_q  <= infl_last_d;
      buf_data_q   <= buf_data_d;
      buf_port_q   <= buf_port_d;
      buf_last_q   <= buf_last_d;
      occ_q        <= occ_d;
      pkt_abort_q  <= pkt_abort_d;
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb/tb_router_out_arbiter.sv - self-checking bench for router_out_arbiter
module tb_router_out_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_0 = 1'b0, vld_1 = 1'b0, vld_2 = 1'b0;
  logic [7:0] data_0 = 8'd0, data_1 = 8'd0, data_2 = 8'd0;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [1:0] m_port;
  logic       m_last, pkt_abort, busy;

  router_out_arbiter #(.TIMEOUT_EN(1)) dut (
    .clock(clock), .reset(reset),
    .vld_0(vld_0), .vld_1(vld_1), .vld_2(vld_2),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_port(m_port),
    .m_last(m_last), .pkt_abort(pkt_abort), .busy(busy)
  );

  always #5 clock = ~clock;

  // Source FIFO contents and the per-port expected output streams ({last, byte}).
  logic [7:0] q0[$], q1[$], q2[$];
  logic [8:0] e0[$], e1[$], e2[$];
  logic [7:0] last_pkt[$];
  logic [7:0] obs_data[$];
  logic [1:0] obs_port[$];
  logic       obs_last[$];
  logic [1:0] pkt_order[$];

  logic [2:0] gap = 3'b000, sr = 3'b000, rd_last;
  logic       busy_last, abort_last;
  logic       sb_en = 1'b1, out_en = 1'b1;
  logic       prev_stall, in_pkt, mid_pkt;
  logic [7:0] prev_data;
  logic [1:0] prev_port, cur_port;
  logic       prev_lst;
  int         total = 0, bad = 0;
  int         rd_cnt[3];
  int         reads_tot, acc_tot, abort_cnt, busy_cnt, first_xfer, cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int p, input logic [7:0] b, input logic l);
    case (p)
      0: begin q0.push_back(b); e0.push_back({l, b}); end
      1: begin q1.push_back(b); e1.push_back({l, b}); end
      default: begin q2.push_back(b); e2.push_back({l, b}); end
    endcase
    last_pkt.push_back(b);
  endtask

  task automatic push_pkt(input int p, input int len);
    logic [7:0] b, par;
    logic [5:0] l6;
    last_pkt.delete();
    l6  = 6'(len);
    par = {l6, 2'b00};
    push_byte(p, par, 1'b0);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      par ^= b;
      push_byte(p, b, 1'b0);
    end
    push_byte(p, par, 1'b1);
  endtask

  task automatic fifo_take(input int p, output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'd0;
    case (p)
      0: if (q0.size() != 0) begin b = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() != 0) begin b = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin b = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic exp_take(input int p, output logic [8:0] v, output logic ok);
    ok = 1'b0;
    v  = 9'd0;
    case (p)
      0: if (e0.size() != 0) begin v = e0.pop_front(); ok = 1'b1; end
      1: if (e1.size() != 0) begin v = e1.pop_front(); ok = 1'b1; end
      2: if (e2.size() != 0) begin v = e2.pop_front(); ok = 1'b1; end
      default: ok = 1'b0;
    endcase
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic tick();
    logic [7:0] nd [3];
    logic [2:0] rd;
    logic [8:0] ev;
    logic       ok;
    vld_0 = (q0.size() != 0) && !gap[0];
    vld_1 = (q1.size() != 0) && !gap[1];
    vld_2 = (q2.size() != 0) && !gap[2];
    soft_reset_0 = sr[0];
    soft_reset_1 = sr[1];
    soft_reset_2 = sr[2];
    #1;
    rd = {read_enb_2, read_enb_1, read_enb_0};
    rd_last    = rd;
    busy_last  = busy;
    abort_last = pkt_abort;
    if (!reset) begin
      chk("rd_onehot", 32'($countones(rd) <= 1), 1);
      for (int p = 0; p < 3; p++) begin
        if (rd[p]) begin
          fifo_take(p, nd[p], ok);
          chk("rd_nonempty", ok, 1);
          rd_cnt[p]++;
          reads_tot++;
        end
      end
      if (pkt_abort) abort_cnt++;
      if (busy) busy_cnt++;
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_port", m_port, prev_port);
        chk("hold_last", m_last, prev_lst);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_port  = m_port;
      prev_lst   = m_last;
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_port.push_back(m_port);
        obs_last.push_back(m_last);
        acc_tot++;
        if (first_xfer < 0) first_xfer = cyc;
        if (!mid_pkt) pkt_order.push_back(m_port);
        mid_pkt = !m_last;
        if (sb_en) begin
          exp_take(int'(m_port), ev, ok);
          chk("sb_have", ok, 1);
          if (ok) chk("sb_byte", {m_last, m_data}, ev);
          if (in_pkt) chk("sb_contig", m_port, cur_port);
          in_pkt   = !m_last;
          cur_port = m_port;
        end
      end
      if (out_en) chk("outstanding", 32'((reads_tot - acc_tot) <= 2), 1);
      cyc++;
    end
    @(posedge clock);
    @(negedge clock);
    if (!reset) begin
      if (rd[0]) data_0 = nd[0];
      if (rd[1]) data_1 = nd[1];
      if (rd[2]) data_2 = nd[2];
    end
    if (sr[0]) q0.delete();
    if (sr[1]) q1.delete();
    if (sr[2]) q2.delete();
    sr = 3'b000;
  endtask

  task automatic clear_logs();
    obs_data.delete(); obs_port.delete(); obs_last.delete(); pkt_order.delete();
    for (int p = 0; p < 3; p++) rd_cnt[p] = 0;
    abort_cnt = 0; busy_cnt = 0; first_xfer = -1; cyc = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_read_enb", rd_last, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_port", m_port, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_pkt_abort", pkt_abort, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    reads_tot = 0; acc_tot = 0;
    prev_stall = 1'b0; in_pkt = 1'b0; mid_pkt = 1'b0;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] sp [5];
    logic [7:0] p0[$], p2[$];
    int j, m, n;
    logic seen0;
    sp = '{8'h0C, 8'hAA, 8'hBB, 8'hCC, 8'h5D};

    // Single packet on port 1, loaded while reset is held.
    last_pkt.delete();
    for (int i = 0; i < 5; i++) push_byte(1, sp[i], i == 4);
    do_reset();
    m_ready = 1'b1;
    run(15);
    chk("single_count", obs_data.size(), 5);
    for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
      chk("single_data", obs_data[i], sp[i]);
      chk("single_port", obs_port[i], 1);
      chk("single_last", obs_last[i], i == 4);
    end
    chk("single_reads", rd_cnt[1], 5);
    chk("single_busy_cycles", busy_cnt, 5);
    chk("single_first_latency", first_xfer, 2);

    // Round-robin from reset: 0,1,2 then 0,2.
    do_reset();
    m_ready = 1'b1;
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1);
    run(25);
    chk("rr1_pkts", pkt_order.size(), 3);
    for (int i = 0; i < 3 && i < pkt_order.size(); i++) chk("rr1_order", pkt_order[i], i);
    clear_logs();
    push_pkt(0, 1); push_pkt(2, 1);
    run(20);
    chk("rr2_pkts", pkt_order.size(), 2);
    if (pkt_order.size() == 2) begin
      chk("rr2_first", pkt_order[0], 0);
      chk("rr2_second", pkt_order[1], 2);
    end

    // Back-pressure: m_ready low for cycles 3..8.
    clear_logs();
    push_pkt(0, 4);
    for (int k = 0; k < 30; k++) begin
      m_ready = !(k >= 3 && k <= 8);
      tick();
    end
    chk("bp_count", obs_data.size(), 6);
    chk("bp_drained", e0.size(), 0);

    // Source underflow: vld_1 dropped for 5 cycles mid-payload.
    clear_logs();
    m_ready = 1'b1;
    push_pkt(1, 6);
    for (int k = 0; k < 30; k++) begin
      gap[1] = (k >= 4 && k <= 8);
      tick();
      if (k >= 4 && k <= 8) begin
        chk("uf_no_read", rd_last[1], 0);
        chk("uf_busy", busy_last, 1);
      end
    end
    gap = 3'b000;
    chk("uf_count", obs_data.size(), 8);
    chk("uf_drained", e1.size(), 0);

    // Abort during BODY of an L=10 packet on port 2, port 0 pending.
    clear_logs();
    sb_en = 1'b0; out_en = 1'b0;
    push_pkt(2, 10); p2 = last_pkt;
    push_pkt(0, 2);  p0 = last_pkt;
    run(5);
    sr[2] = 1'b1;
    tick();
    chk("abort_no_read", rd_last[2], 0);
    tick();
    chk("abort_pulse", abort_last, 1);
    chk("abort_idle", busy_last, 0);
    run(20);
    chk("abort_once", abort_cnt, 1);
    j = 0; m = 0; seen0 = 1'b0;
    for (int i = 0; i < obs_data.size(); i++) begin
      if (obs_port[i] == 2'd2) begin
        chk("abort_after_next", seen0, 0);
        chk("abort_no_last", obs_last[i], 0);
        if (j < p2.size()) chk("abort_prefix", obs_data[i], p2[j]);
        j++;
      end else begin
        seen0 = 1'b1;
        chk("abort_next_port", obs_port[i], 0);
        if (m < p0.size()) begin
          chk("abort_next_data", obs_data[i], p0[m]);
          chk("abort_next_last", obs_last[i], m == p0.size() - 1);
        end
        m++;
      end
    end
    chk("abort_bytes_kept", j, 3);
    chk("abort_next_count", m, p0.size());
    e0.delete(); e2.delete();
    sb_en = 1'b1; out_en = 1'b1;

    // Zero-length packet.
    do_reset();
    m_ready = 1'b1;
    last_pkt.delete();
    push_byte(1, 8'h00, 1'b0);
    push_byte(1, 8'h9E, 1'b1);
    run(12);
    chk("zero_count", obs_data.size(), 2);
    if (obs_data.size() == 2) begin
      chk("zero_hdr", obs_data[0], 8'h00);
      chk("zero_hdr_last", obs_last[0], 0);
      chk("zero_par", obs_data[1], 8'h9E);
      chk("zero_par_last", obs_last[1], 1);
    end

    // Randomized traffic with random back-pressure and source gaps.
    clear_logs();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 2; k++) push_pkt(p, int'($urandom_range(0, 12)));
    n = 0;
    while ((e0.size() + e1.size() + e2.size()) != 0 && n < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      gap = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      tick();
      n++;
    end
    gap = 3'b000;
    chk("rand_drained", e0.size() + e1.size() + e2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
